// File: rtl/autoconfig_pkg.sv
// Shared definitions for the Zorro autoconfig chain: board identity tables,
// the per-board config ROM lookup, FSM state encoding and the write offsets
// the chain reacts to.
package autoconfig_pkg;

  localparam int unsigned MAX_BOARDS = 4;

  // Register offsets within config space, as zaddr = A[6:1]
  localparam logic [5:0] OFF_BASE   = 6'h22;
  localparam logic [5:0] OFF_SHUTUP = 6'h26;

  typedef enum logic [1:0] {IDLE, CYCLE, DONE} state_t;

  // ER_TYPE holds the two uninverted nibbles presented at offsets 00/01
  localparam logic [7:0]  ER_TYPE      [MAX_BOARDS] = '{8'hA3, 8'hC5, 8'hA3, 8'hC5};
  localparam logic [7:0]  PRODUCT      [MAX_BOARDS] = '{8'h03, 8'h04, 8'h05, 8'h06};
  localparam logic [15:0] MANUFACTURER [MAX_BOARDS] = '{16'h13D8, 16'h13D8, 16'h13D8, 16'h13D8};
  localparam logic [15:0] SERIAL       [MAX_BOARDS] = '{16'h0000, 16'h0001, 16'h0002, 16'h0003};
  localparam int unsigned SIZE_LOG2    [MAX_BOARDS] = '{23, 20, 20, 16};

  // Everything past offset 01 is stored inverted on the bus, hence the '~'.
  function automatic logic [3:0] rom_nibble(input logic [2:0] board, input logic [5:0] zaddr);
    logic [1:0] b;
    logic [3:0] n;
    b = board[1:0];
    n = 4'hF;
    if (board < 3'(MAX_BOARDS)) begin
      case (zaddr)
        6'h00:   n = ER_TYPE[b][7:4];
        6'h01:   n = ER_TYPE[b][3:0];
        6'h02:   n = ~PRODUCT[b][7:4];
        6'h03:   n = ~PRODUCT[b][3:0];
        6'h04:   n = 4'h4;
        6'h08:   n = ~MANUFACTURER[b][15:12];
        6'h09:   n = ~MANUFACTURER[b][11:8];
        6'h0A:   n = ~MANUFACTURER[b][7:4];
        6'h0B:   n = ~MANUFACTURER[b][3:0];
        6'h0C:   n = ~SERIAL[b][15:12];
        6'h0D:   n = ~SERIAL[b][11:8];
        6'h0E:   n = ~SERIAL[b][7:4];
        6'h0F:   n = ~SERIAL[b][3:0];
        6'h11:   n = 4'hE;
        6'h12:   n = 4'hB;
        6'h13:   n = 4'h5;
        default: n = 4'hF;
      endcase
    end
    return n;
  endfunction

endpackage

// File: rtl/autoconfig_sync.sv
// N-stage synchroniser for an active-low strobe; resets to 1 (negated).
// Ports: clk, rst (async, active high), d (async input), q (synchronised).
module autoconfig_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr <= '1;
    else     sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/autoconfig_chain.sv
// Autoconfig responder for a chain of NUM_BOARDS boards presented one after
// another in the 0xE8xxxx config space of a 68030 bus.
// Optional feature: define AUTOCONFIG_SHUTUP_EN to honour shut-up writes.
// Ports:
//   CLK    block clock (faster than the CPU bus)
//   RESET  asynchronous, active-high reset
//   AS20, DS20  CPU address/data strobes (active low), RW20 (1 = read)
//   A      CPU address, D  CPU data D[31:16] (base address capture)
//   DOUT   config nibble for D[31:28] of the bus, held until the next read
//   ACCESS active-low claim of the current config-space cycle
//   DECODE active-low memory select per configured board
module autoconfig_chain
  import autoconfig_pkg::*;
#(
  parameter int unsigned NUM_BOARDS  = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  AS20,
  input  logic                  DS20,
  input  logic                  RW20,
  input  logic [31:0]           A,
  input  logic [15:0]           D,
  output logic [7:4]            DOUT,
  output logic                  ACCESS,
  output logic [NUM_BOARDS-1:0] DECODE
);

  logic as_s, ds_s, rw_s;
  logic as_q, ds_q;
  logic ds_fall, as_rise;

  state_t state, next_state;
  logic [2:0] cur;
  logic [NUM_BOARDS-1:0] configured;
  logic [NUM_BOARDS-1:0] shutup;
  logic [15:0] base [NUM_BOARDS];
  logic pending;
  logic claim;
  logic [5:0] zaddr;
  logic load_dout, wr_base, wr_shut, advance;

  autoconfig_sync #(.STAGES(SYNC_STAGES)) u_sync_as (.clk(CLK), .rst(RESET), .d(AS20), .q(as_s));
  autoconfig_sync #(.STAGES(SYNC_STAGES)) u_sync_ds (.clk(CLK), .rst(RESET), .d(DS20), .q(ds_s));
  autoconfig_sync #(.STAGES(SYNC_STAGES)) u_sync_rw (.clk(CLK), .rst(RESET), .d(RW20), .q(rw_s));

  assign ds_fall = ds_q & ~ds_s;
  assign as_rise = ~as_q & as_s;

  assign zaddr  = A[6:1];
  assign claim  = (A[31:16] == 16'h00E8) && (cur < 3'(NUM_BOARDS));
  assign ACCESS = ~claim;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      as_q  <= 1'b1;
      ds_q  <= 1'b1;
    end else begin
      state <= next_state;
      as_q  <= as_s;
      ds_q  <= ds_s;
    end
  end

  always_comb begin
    next_state = state;
    load_dout  = 1'b0;
    wr_base    = 1'b0;
    wr_shut    = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: if (ds_fall && claim) next_state = CYCLE;
      CYCLE: begin
        // An AS20 negation seen here means the CPU gave up the cycle.
        if (as_rise) begin
          next_state = IDLE;
        end else begin
          next_state = DONE;
          if (rw_s) load_dout = 1'b1;
          else if (zaddr == OFF_BASE) wr_base = 1'b1;
`ifdef AUTOCONFIG_SHUTUP_EN
          else if (zaddr == OFF_SHUTUP) wr_shut = 1'b1;
`endif
        end
      end
      DONE: begin
        if (as_rise) begin
          next_state = IDLE;
          advance    = pending;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Board switch is deferred to AS20 negation so the CPU finishes the write
  // against the board it addressed.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cur        <= '0;
      DOUT       <= 4'hF;
      configured <= '0;
      pending    <= 1'b0;
      for (int unsigned i = 0; i < NUM_BOARDS; i++) base[i] <= '0;
    end else begin
      if (load_dout) DOUT <= rom_nibble(cur, zaddr);
      if (wr_base) begin
        for (int unsigned i = 0; i < NUM_BOARDS; i++) begin
          if (cur == 3'(i)) begin
            base[i]       <= D;
            configured[i] <= 1'b1;
          end
        end
      end
      if (wr_base || wr_shut)     pending <= 1'b1;
      else if (next_state == IDLE) pending <= 1'b0;
      if (advance && (cur < 3'(NUM_BOARDS))) cur <= cur + 3'd1;
    end
  end

`ifdef AUTOCONFIG_SHUTUP_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      shutup <= '0;
    end else if (wr_shut) begin
      for (int unsigned i = 0; i < NUM_BOARDS; i++) begin
        if (cur == 3'(i)) shutup[i] <= 1'b1;
      end
    end
  end
`else
  assign shutup = '0;
`endif

  for (genvar g = 0; g < NUM_BOARDS; g++) begin : g_decode
    localparam logic [31:0] MASK = 32'hFFFF_FFFF << SIZE_LOG2[g];
    assign DECODE[g] = ~(configured[g] & ~shutup[g] &
                         (((A ^ {base[g], 16'h0000}) & MASK) == '0));
  end

endmodule

// File: tb/tb_autoconfig_chain.sv
module tb_autoconfig_chain;

  localparam int SYNC = 2;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        AS20 = 1'b1;
  logic        DS20 = 1'b1;
  logic        RW20 = 1'b1;
  logic [31:0] A = '0;
  logic [15:0] D = '0;
  logic [7:4]  DOUT;
  logic        ACCESS;
  logic [1:0]  DECODE;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  autoconfig_chain #(.NUM_BOARDS(2), .SYNC_STAGES(SYNC)) dut (
    .CLK(CLK), .RESET(RESET), .AS20(AS20), .DS20(DS20), .RW20(RW20),
    .A(A), .D(D), .DOUT(DOUT), .ACCESS(ACCESS), .DECODE(DECODE)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  // Read samples DOUT exactly SYNC+2 clocks after DS20 falls.
  task automatic cpu_read(input logic [5:0] z, output logic [3:0] val);
    @(negedge CLK);
    A = 32'h00E8_0000 | {25'd0, z, 1'b0};
    RW20 = 1'b1; AS20 = 1'b0; DS20 = 1'b0;
    repeat (SYNC + 2) @(posedge CLK);
    #1 val = DOUT;
    @(negedge CLK);
    AS20 = 1'b1; DS20 = 1'b1;
    repeat (6) @(posedge CLK);
  endtask

  task automatic cpu_write(input logic [5:0] z, input logic [15:0] data);
    @(negedge CLK);
    A = 32'h00E8_0000 | {25'd0, z, 1'b0};
    RW20 = 1'b0; D = data; AS20 = 1'b0; DS20 = 1'b0;
    repeat (SYNC + 4) @(posedge CLK);
    @(negedge CLK);
    AS20 = 1'b1; DS20 = 1'b1;
    repeat (6) @(posedge CLK);
    @(negedge CLK);
    RW20 = 1'b1;
  endtask

  task automatic set_addr(input logic [31:0] a);
    @(negedge CLK);
    A = a;
    #1;
  endtask

  task automatic test_reset;
    RESET = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    tests++; if (DOUT !== 4'hF) begin fails++; $display("FAIL reset_dout: got %h expected f", DOUT); end
    set_addr(32'h00E8_0000);
    tests++; if (ACCESS !== 1'b0) begin fails++; $display("FAIL reset_access: got %b expected 0", ACCESS); end
    tests++; if (DECODE !== 2'b11) begin fails++; $display("FAIL reset_decode: got %b expected 11", DECODE); end
    set_addr(32'h00E9_0000);
    tests++; if (ACCESS !== 1'b1) begin fails++; $display("FAIL access_outside: got %b expected 1", ACCESS); end
    @(negedge CLK);
    RESET = 1'b0;
    repeat (2) @(posedge CLK);
  endtask

  task automatic test_read_board0;
    logic [5:0] z   [4] = '{6'h00, 6'h01, 6'h13, 6'h05};
    logic [3:0] exp [4] = '{4'hA, 4'h3, 4'h5, 4'hF};
    logic [3:0] v;
    for (int i = 0; i < 4; i++) begin
      cpu_read(z[i], v);
      tests++;
      if (v !== exp[i]) begin
        fails++; $display("FAIL read_b0_z%h: got %h expected %h", z[i], v, exp[i]);
      end
    end
    set_addr(32'h00E8_0000);
    tests++; if (ACCESS !== 1'b0) begin fails++; $display("FAIL read_access: got %b expected 0", ACCESS); end
  endtask

  // Strobes negate after one clock, so AS20's synced rise lands in CYCLE.
  task automatic test_abort;
    logic [3:0] v;
    @(negedge CLK);
    A = 32'h00E8_0044; RW20 = 1'b0; D = 16'h4000; AS20 = 1'b0; DS20 = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    AS20 = 1'b1; DS20 = 1'b1;
    repeat (8) @(posedge CLK);
    @(negedge CLK);
    RW20 = 1'b1;
    set_addr(32'h4000_0000);
    tests++; if (DECODE[0] !== 1'b1) begin fails++; $display("FAIL abort_decode: got %b expected 1", DECODE[0]); end
    cpu_read(6'h00, v);
    tests++; if (v !== 4'hA) begin fails++; $display("FAIL abort_cur: got %h expected a", v); end
  endtask

  task automatic test_configure;
    logic [3:0] v;
    cpu_write(6'h22, 16'h4000);
    set_addr(32'h4000_0000);
    tests++; if (DECODE !== 2'b10) begin fails++; $display("FAIL cfg_hit: got %b expected 10", DECODE); end
    set_addr(32'h4800_0000);
    tests++; if (DECODE[0] !== 1'b1) begin fails++; $display("FAIL cfg_miss: got %b expected 1", DECODE[0]); end
    set_addr(32'h407F_FFFE);
    tests++; if (DECODE[0] !== 1'b0) begin fails++; $display("FAIL cfg_top: got %b expected 0", DECODE[0]); end
    set_addr(32'h4080_0000);
    tests++; if (DECODE[0] !== 1'b1) begin fails++; $display("FAIL cfg_above: got %b expected 1", DECODE[0]); end
    set_addr(32'h00E8_0000);
    tests++; if (ACCESS !== 1'b0) begin fails++; $display("FAIL cfg_access_b1: got %b expected 0", ACCESS); end
    cpu_read(6'h00, v);
    tests++; if (v !== 4'hC) begin fails++; $display("FAIL read_b1_z00: got %h expected c", v); end
    cpu_read(6'h01, v);
    tests++; if (v !== 4'h5) begin fails++; $display("FAIL read_b1_z01: got %h expected 5", v); end
  endtask

  task automatic test_configure_all;
    logic [3:0] v;
    cpu_write(6'h22, 16'h2000);
    set_addr(32'h2000_0000);
    tests++; if (DECODE !== 2'b01) begin fails++; $display("FAIL b1_hit: got %b expected 01", DECODE); end
    set_addr(32'h2010_0000);
    tests++; if (DECODE !== 2'b11) begin fails++; $display("FAIL b1_above: got %b expected 11", DECODE); end
    set_addr(32'h00E8_0000);
    tests++; if (ACCESS !== 1'b1) begin fails++; $display("FAIL done_access: got %b expected 1", ACCESS); end
    cpu_write(6'h22, 16'h6000);
    set_addr(32'h6000_0000);
    tests++; if (DECODE !== 2'b11) begin fails++; $display("FAIL late_write_new: got %b expected 11", DECODE); end
    set_addr(32'h2000_0000);
    tests++; if (DECODE !== 2'b01) begin fails++; $display("FAIL late_write_b1: got %b expected 01", DECODE); end
    set_addr(32'h4000_0000);
    tests++; if (DECODE !== 2'b10) begin fails++; $display("FAIL late_write_b0: got %b expected 10", DECODE); end
    cpu_read(6'h00, v);
    tests++; if (v !== 4'h5) begin fails++; $display("FAIL unclaimed_read: got %h expected 5", v); end
  endtask

  // Reset lands while the FSM sits in CYCLE of a base write.
  task automatic test_reset_mid_write;
    logic [3:0] v;
    @(negedge CLK);
    A = 32'h00E8_0044; RW20 = 1'b0; D = 16'h4000; AS20 = 1'b0; DS20 = 1'b0;
    repeat (SYNC + 1) @(posedge CLK);
    #1 RESET = 1'b1;
    @(negedge CLK);
    AS20 = 1'b1; DS20 = 1'b1; RW20 = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    tests++; if (DOUT !== 4'hF) begin fails++; $display("FAIL rst_mid_dout: got %h expected f", DOUT); end
    set_addr(32'h4000_0000);
    tests++; if (DECODE !== 2'b11) begin fails++; $display("FAIL rst_mid_decode: got %b expected 11", DECODE); end
    set_addr(32'h00E8_0000);
    tests++; if (ACCESS !== 1'b0) begin fails++; $display("FAIL rst_mid_access: got %b expected 0", ACCESS); end
    cpu_read(6'h00, v);
    tests++; if (v !== 4'hA) begin fails++; $display("FAIL rst_mid_cur: got %h expected a", v); end
  endtask

  task automatic test_shutup;
    logic [3:0] v;
    logic [3:0] exp;
`ifdef AUTOCONFIG_SHUTUP_EN
    exp = 4'hC;
`else
    exp = 4'hA;
`endif
    cpu_write(6'h26, 16'h0000);
    set_addr(32'h0000_0000);
    tests++; if (DECODE[0] !== 1'b1) begin fails++; $display("FAIL shutup_decode: got %b expected 1", DECODE[0]); end
    set_addr(32'h00E8_0000);
    tests++; if (ACCESS !== 1'b0) begin fails++; $display("FAIL shutup_access: got %b expected 0", ACCESS); end
    cpu_read(6'h00, v);
    tests++; if (v !== exp) begin fails++; $display("FAIL shutup_cur: got %h expected %h", v, exp); end
  endtask

  initial begin
    test_reset();
    test_read_board0();
    test_abort();
    test_configure();
    test_configure_all();
    test_reset_mid_write();
    test_shutup();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
